// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube display stage.
//   scan_state_t   : layer-scanner FSM states
//   DEFAULT_N      : default cube edge length
//   GPIO_W         : width of the GPIO_0 header bus
//   COL_LSB        : bit offset of the column field on GPIO_0
//   LAYER_LSB      : bit offset of the layer field on GPIO_0 (default N)
//   layer_lsb()    : layer field offset for an arbitrary edge length
//   inactive_level(): pin level that turns a pin off for a given polarity
package led_cube_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned GPIO_W    = 36;
    localparam int unsigned COL_LSB   = 0;
    localparam int unsigned LAYER_LSB = DEFAULT_N * DEFAULT_N;

    // Layer pins sit directly above the N*N column pins.
    function automatic int unsigned layer_lsb(input int unsigned n);
        return n * n;
    endfunction

    // An active-high pin is off at 0, an active-low pin is off at 1.
    function automatic logic inactive_level(input bit active_high);
        return ~active_high;
    endfunction

endpackage

// File: rtl/led_cube_frame_buffer.sv
// Double-buffered frame store for the LED cube.
//   clk, reset_n : clock, async active-low reset (banks are not cleared)
//   wr_en/wr_layer/wr_data : registered write of one layer word into the back bank
//   swap_req     : request to present the back bank at the next frame boundary
//   frame_wrap   : high in the cycle the scanner wraps from layer N-1 to 0
//   rd_layer     : layer read from the display bank
//   rd_data_c    : combinational read data
//   swap_done    : registered one-cycle pulse when the display bank flips
module led_cube_frame_buffer
    import led_cube_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned WR_LAYER_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WR_LAYER_W-1:0] wr_layer,
    input  logic [N*N-1:0]        wr_data,
    input  logic                  swap_req,
    input  logic                  frame_wrap,
    input  logic [$clog2(N)-1:0]  rd_layer,
    output logic [N*N-1:0]        rd_data_c,
    output logic                  swap_done
);

    localparam int unsigned LW = $clog2(N);

    logic [N*N-1:0] mem_q [2][N];
    logic           display_bank_q, display_bank_d;
    logic           pending_q, pending_d;
    logic           swap_done_q, swap_done_d;
    logic           flip;
    logic           wr_bank;
    logic           wr_ok;
    int unsigned    wr_layer_idx;

    // Swap bookkeeping; a request arriving on the wrap cycle itself still flips.
    always_comb begin
        flip           = frame_wrap && (pending_q || swap_req);
        display_bank_d = display_bank_q ^ flip;
        pending_d      = flip ? 1'b0 : (pending_q || swap_req);
        swap_done_d    = flip;
        // Writes target the bank that will be in the back after this edge.
        wr_bank        = ~display_bank_d;
        wr_layer_idx   = 32'(wr_layer);
        wr_ok          = wr_en && (wr_layer_idx < N);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display_bank_q <= 1'b0;
            pending_q      <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            display_bank_q <= display_bank_d;
            pending_q      <= pending_d;
            swap_done_q    <= swap_done_d;
        end
    end

    // Frame storage keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_bank][LW'(wr_layer)] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[display_bank_q][rd_layer];
    assign swap_done = swap_done_q;

endmodule

// File: rtl/led_cube_layer_scanner.sv
// Layer-multiplexed LED cube driver with double-buffered frames,
// per-layer blanking and 8-bit PWM brightness.
//   clk, reset_n : 50 MHz clock, async active-low reset
//   enable       : scan enable; low returns to IDLE with pins off
//   brightness   : PWM duty threshold (0 = dark)
//   wr_en/wr_layer/wr_data : layer word write into the back bank
//   swap_req     : present the back bank at the next frame boundary
//   swap_done    : pulse when the bank flip takes effect
//   frame_tick   : pulse at each layer N-1 -> 0 wrap
//   cur_layer    : layer being scanned
//   gpio         : [N*N-1:0] columns, [N*N+N-1:N*N] layers, rest 0
module led_cube_layer_scanner
    import led_cube_pkg::*;
#(
    parameter int unsigned N                 = DEFAULT_N,
    parameter int unsigned DWELL_CYCLES      = 12500,
    parameter int unsigned BLANK_CYCLES      = 50,
    parameter bit          COL_ACTIVE_HIGH   = 1'b1,
    parameter bit          LAYER_ACTIVE_HIGH = 1'b0,
    parameter int unsigned WR_LAYER_W        = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [7:0]            brightness,
    input  logic                  wr_en,
    input  logic [WR_LAYER_W-1:0] wr_layer,
    input  logic [N*N-1:0]        wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  frame_tick,
    output logic [$clog2(N)-1:0]  cur_layer,
    output logic [GPIO_W-1:0]     gpio
);

    localparam int unsigned LW        = $clog2(N);
    localparam int unsigned NCOL      = N * N;
    localparam int unsigned LAYER_OFS = layer_lsb(N);
    localparam int unsigned CNT_MAX   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic        COL_OFF   = inactive_level(COL_ACTIVE_HIGH);
    localparam logic        LAYER_OFF = inactive_level(LAYER_ACTIVE_HIGH);

    function automatic logic [GPIO_W-1:0] pack_gpio(input logic [NCOL-1:0] cols,
                                                    input logic [N-1:0]    layers);
        logic [GPIO_W-1:0] g;
        g                     = '0;
        g[COL_LSB +: NCOL]    = cols;
        g[LAYER_OFS +: N]     = layers;
        return g;
    endfunction

    localparam logic [GPIO_W-1:0] GPIO_IDLE = pack_gpio({NCOL{COL_OFF}}, {N{LAYER_OFF}});

    scan_state_t       state_q, state_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pwm_q, pwm_d;
    logic [NCOL-1:0]   col_reg_q, col_reg_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic              frame_tick_q, frame_tick_d;
    logic              frame_wrap;
    logic [NCOL-1:0]   rd_data;
    logic [NCOL-1:0]   col_on;
    logic [N-1:0]      layer_on;

    led_cube_frame_buffer #(
        .N          (N),
        .WR_LAYER_W (WR_LAYER_W)
    ) u_frame_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_layer   (wr_layer),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .frame_wrap (frame_wrap),
        .rd_layer   (layer_q),
        .rd_data_c  (rd_data),
        .swap_done  (swap_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            layer_q      <= '0;
            cnt_q        <= '0;
            pwm_q        <= '0;
            col_reg_q    <= '0;
            gpio_q       <= GPIO_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            col_reg_q    <= col_reg_d;
            gpio_q       <= gpio_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Next-state: blank window, lit window, layer advance and frame wrap.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        cnt_d      = cnt_q;
        pwm_d      = pwm_q;
        col_reg_d  = col_reg_q;
        frame_wrap = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            layer_d = '0;
            cnt_d   = '0;
            pwm_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    layer_d = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    // Latch on the first blank cycle so a bank flip at the wrap is seen.
                    if (cnt_q == '0) begin
                        col_reg_d = rd_data;
                    end
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_d = ON;
                        cnt_d   = '0;
                        pwm_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ON: begin
                    pwm_d = pwm_q + 8'd1;
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (layer_q == LW'(N - 1)) begin
                            layer_d    = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            layer_d = layer_q + LW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    layer_d = '0;
                    cnt_d   = '0;
                    pwm_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next-state values so the registered pins line up with state_q.
    always_comb begin
        col_on       = '0;
        layer_on     = '0;
        frame_tick_d = frame_wrap;
        if (state_d == ON) begin
            layer_on[layer_d] = 1'b1;
            if (pwm_d < brightness) begin
                col_on = col_reg_d;
            end
        end
        gpio_d = pack_gpio(col_on ^ {NCOL{COL_OFF}}, layer_on ^ {N{LAYER_OFF}});
    end

    assign gpio       = gpio_q;
    assign frame_tick = frame_tick_q;
    assign cur_layer  = layer_q;

endmodule

// File: tb/tb_led_cube_layer_scanner.sv
// Self-checking bench for led_cube_layer_scanner against a frame-position reference model.
module tb_led_cube_layer_scanner;

    localparam int N     = 4;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int P     = DWELL + BLANK;
    localparam int FRAME = N * P;
    localparam logic [35:0] GPIO_IDLE = 36'h0000F0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  brightness = 8'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_layer = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic        frame_tick;
    logic [1:0]  cur_layer;
    logic [35:0] gpio;

    always #5 clk = ~clk;

    led_cube_layer_scanner #(
        .N                 (N),
        .DWELL_CYCLES      (DWELL),
        .BLANK_CYCLES      (BLANK),
        .COL_ACTIVE_HIGH   (1'b1),
        .LAYER_ACTIVE_HIGH (1'b0),
        .WR_LAYER_W        (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .brightness (brightness),
        .wr_en      (wr_en),
        .wr_layer   (wr_layer),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_done  (swap_done),
        .frame_tick (frame_tick),
        .cur_layer  (cur_layer),
        .gpio       (gpio)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: position within the frame is a single cycle index.
    bit          m_run;
    int          m_k;
    bit          m_disp;
    bit          m_pend;
    logic [15:0] m_bank [2][N];
    bit          m_known [2][N];
    logic [15:0] m_latch [N];
    bit          m_latch_ok [N];
    bit          m_tick;
    bit          m_done;
    logic [35:0] m_gpio;
    logic [35:0] m_mask;
    int          m_layer;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lay(input int k);
        return (k / P) % N;
    endfunction

    function automatic int off(input int k);
        return k % P;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_k     = 0;
        m_disp  = 1'b0;
        m_pend  = 1'b0;
        m_tick  = 1'b0;
        m_done  = 1'b0;
        m_gpio  = GPIO_IDLE;
        m_mask  = '1;
        m_layer = 0;
    endtask

    // Apply the inputs seen at this rising edge to the model.
    task automatic model_update();
        bit boundary;
        bit flip;
        int l;
        int o;
        boundary = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
            m_k   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_k   = 0;
        end else begin
            boundary = ((m_k + 1) % FRAME == 0);
            m_k      = (m_k + 1) % FRAME;
        end
        flip = boundary && (m_pend || swap_req);
        if (flip) begin
            m_disp = !m_disp;
            m_pend = 1'b0;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        if (wr_en && int'(wr_layer) < N) begin
            m_bank[int'(!m_disp)][wr_layer]  = wr_data;
            m_known[int'(!m_disp)][wr_layer] = 1'b1;
        end
        m_tick  = boundary;
        m_done  = flip;
        m_gpio  = GPIO_IDLE;
        m_mask  = '1;
        m_layer = 0;
        if (m_run) begin
            l       = lay(m_k);
            o       = off(m_k);
            m_layer = l;
            if (o == 0) begin
                m_latch[l]    = m_bank[int'(m_disp)][l];
                m_latch_ok[l] = m_known[int'(m_disp)][l];
            end
            if (o >= BLANK) begin
                m_gpio[16 + l] = 1'b0;
                if (((o - BLANK) % 256) < int'(brightness)) begin
                    m_gpio[15:0] = m_latch[l];
                end
                if (!m_latch_ok[l]) begin
                    m_mask[15:0] = '0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_eq("gpio", gpio & m_mask, m_gpio & m_mask);
        check_eq("cur_layer", cur_layer, m_layer);
        check_eq("frame_tick", frame_tick, m_tick);
        check_eq("swap_done", swap_done, m_done);
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic write_word(input int layer, input logic [15:0] data);
        wr_en    = 1'b1;
        wr_layer = 3'(layer);
        wr_data  = data;
        step();
    endtask

    task automatic wait_swap_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            step();
            if (swap_done) begin
                seen = 1'b1;
                check_eq("done_with_tick", frame_tick, 1);
            end
        end
        check_eq("swap_wait", seen, 1);
    endtask

    task automatic run_count(input int cycles, output int col_cycles, output int ticks);
        col_cycles = 0;
        ticks      = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (gpio[15:0] != 16'h0) col_cycles++;
            if (frame_tick) ticks++;
        end
    endtask

    task automatic wait_boundary_next();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            if (m_run && enable && ((m_k + 1) % FRAME == 0)) hit = 1'b1;
            else step();
        end
        check_eq("boundary_wait", hit, 1);
    endtask

    task automatic wait_layer_on(input int l);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            if (m_run && lay(m_k) == l && off(m_k) >= BLANK + 3) hit = 1'b1;
            else step();
        end
        check_eq("layer_wait", hit, 1);
    endtask

    initial begin
        int on_cnt;
        int tk_cnt;
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < N; l++) begin
                m_bank[b][l]  = '0;
                m_known[b][l] = 1'b0;
            end
        end
        for (int l = 0; l < N; l++) begin
            m_latch[l]    = '0;
            m_latch_ok[l] = 1'b0;
        end
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_gpio", gpio, GPIO_IDLE);
        check_eq("rst_layer", cur_layer, 0);
        check_eq("rst_tick", frame_tick, 0);
        check_eq("rst_done", swap_done, 0);
        reset_n = 1'b1;
        step();
        step();

        // Scan start latency
        enable     = 1'b1;
        brightness = 8'd255;
        for (int c = 1; c <= 3; c++) begin
            step();
            check_eq("t1_layer0_pin", gpio[16], (c < 3));
            check_eq("t1_other_layers", gpio[19:17], 3'b111);
            if (c < 3) check_eq("t1_cols_blank", gpio[15:0], 0);
        end
        repeat (20) step();

        // Mid-frame back-bank load and swap
        write_word(0, 16'h0001);
        write_word(1, 16'h0010);
        write_word(2, 16'h0100);
        write_word(3, 16'h1000);
        swap_req = 1'b1;
        step();
        wait_swap_done();
        run_count(FRAME, on_cnt, tk_cnt);
        check_eq("t2_cols_lit", on_cnt, N * DWELL);

        // PWM duty
        for (int l = 0; l < N; l++) write_word(l, 16'hFFFF);
        swap_req = 1'b1;
        step();
        wait_swap_done();
        brightness = 8'd128;
        run_count(FRAME, on_cnt, tk_cnt);
        check_eq("t3_b128_on", on_cnt, N * DWELL);
        brightness = 8'd4;
        run_count(FRAME, on_cnt, tk_cnt);
        check_eq("t3_b4_on", on_cnt, N * 4);

        // Zero brightness
        brightness = 8'd0;
        run_count(FRAME, on_cnt, tk_cnt);
        check_eq("t4_dark", on_cnt, 0);
        check_eq("t4_ticks", tk_cnt, 1);

        // Swap and write on the boundary cycle
        for (int l = 0; l < N; l++) write_word(l, 16'hA5A0 + 16'(l));
        brightness = 8'd255;
        wait_boundary_next();
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_layer = 3'd0;
        wr_data  = 16'h5A5A;
        step();
        check_eq("t5_done_on_boundary", swap_done, 1);
        run_count(FRAME, on_cnt, tk_cnt);

        // Out-of-range layer writes are dropped
        write_word(5, 16'h1234);
        write_word(4, 16'h4321);
        write_word(7, 16'hBEEF);
        swap_req = 1'b1;
        step();
        wait_swap_done();
        run_count(FRAME, on_cnt, tk_cnt);

        // Enable drop mid-ON and restart
        wait_layer_on(2);
        enable = 1'b0;
        step();
        check_eq("t6_gpio_off", gpio, GPIO_IDLE);
        check_eq("t6_layer_zero", cur_layer, 0);
        repeat (3) step();
        enable = 1'b1;
        step();
        check_eq("t6_restart_blank", gpio, GPIO_IDLE);
        repeat (FRAME) step();

        // Asynchronous reset mid-ON
        wait_layer_on(1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_gpio", gpio, GPIO_IDLE);
        check_eq("async_layer", cur_layer, 0);
        check_eq("async_tick", frame_tick, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME) step();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            wr_en    = ($urandom_range(0, 9) < 3);
            wr_layer = 3'($urandom_range(0, 7));
            wr_data  = 16'($urandom);
            swap_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) brightness = 8'($urandom);
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 199) == 0) enable = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
